ddr_rd_req_gen: RTL and testbench
=================================

Name: ddr_rd_req_gen

Overview:
- Downstream consumer of one DDR read channel configuration (start, st_addr, burst, step, burst_num) produced by the instruction decoder in front of the PE buffers.
- Expands a strided 2-D read (burst_num rows of burst beats, row starts step bytes apart) into a sequence of bounded read requests to the DDR interface.
- Counts returned data beats and reports done back to the decoder status logic.
- One instance per DDR port (ddr1, ddr2).

Parameters:
- ADDR_W, 32, byte address width
- BURST_W, 16, width of burst, burst_num and step-related counts
- MAX_LEN, 16, maximum beats per issued request (power of two, at most 256)
- BEAT_BYTES, 32, bytes per data beat (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  single-cycle pulse; configuration is valid in the same cycle
- st_addr  in  ADDR_W  byte address of row 0; must be BEAT_BYTES-aligned
- burst  in  BURST_W  beats per row
- step  in  ADDR_W  byte stride between consecutive row starts
- burst_num  in  BURST_W  number of rows
- done  out  1  level; high when idle, low while a job is in flight
- rd_req_valid  out  1  request valid
- rd_req_ready  in  1  request accepted
- rd_req_addr  out  ADDR_W  request byte address
- rd_req_len  out  8  beats minus 1
- rd_data_valid  in  1  one returned data beat

Behaviour:
- Reset values: done=1, rd_req_valid=0, rd_req_addr=0, rd_req_len=0, all counters 0, state IDLE.
- rst has priority everywhere, including mid-job; outstanding requests are abandoned.
- IDLE:
  - start with burst!=0 and burst_num!=0: latch the configuration, set cur_addr=row_base=st_addr, row_rem=burst, rows_left=burst_num, beats_exp=burst*burst_num (2*BURST_W bits), beats_rcv=0, done<=0, go to REQ.
  - start with burst==0 or burst_num==0: ignored; done stays 1.
  - rd_data_valid is ignored.
- start while not IDLE is ignored; the latched configuration is unchanged.
- REQ:
  - rd_req_valid=1 and rd_req_addr=cur_addr. Asserted the cycle after entry, so first request valid 1 cycle after start.
  - len = min(row_rem, MAX_LEN, beats remaining to the next 4 KiB boundary = (4096 - cur_addr[11:0]) / BEAT_BYTES); rd_req_len = len-1.
  - Addr and len are held stable while valid && !ready.
  - On valid&&ready: cur_addr += len*BEAT_BYTES; row_rem -= len.
  - If row_rem reaches 0: rows_left -= 1, row_base += step, cur_addr = row_base+step, row_rem = burst.
  - If rows_left reaches 0: drop valid the next cycle and go to WAIT.
  - Otherwise the next request is presented with valid staying high; back-to-back accepts give 1 request per cycle.
- WAIT: rd_req_valid=0.
- Beat counting: beats_rcv increments on rd_data_valid in REQ and WAIT.
- Completion: when beats_rcv == beats_exp (checked including the incrementing beat), go to IDLE and set done<=1 the following cycle. This can happen in the same cycle as the last request accept if all data has arrived early.
- Extra beats after completion are ignored.
- Address arithmetic wraps modulo 2^ADDR_W; step=0 re-reads the same row.

Test Plan:
- Single row: st_addr=0x1000, burst=8, burst_num=1, ready=1 → one request, addr 0x1000, len 7. done low from cycle after start until 1 cycle after the 8th data beat.
- Split by MAX_LEN: st_addr=0, burst=40, burst_num=1 → requests (0x000, len 15), (0x200, len 15), (0x400, len 7).
- 4 KiB boundary: st_addr=0x0FC0, burst=4 → (0x0FC0, len 1), (0x1000, len 1).
- Strided rows: st_addr=0x2000, burst=3, step=0x400, burst_num=3 → addrs 0x2000, 0x2400, 0x2800, each len 2. done rises after 9 beats.
- Backpressure and illegal input:
  - rd_req_ready low for 5 cycles → addr/len held stable, no extra request.
  - start during the job → ignored.
  - burst_num=0 start → done stays 1, no request.
- Reset mid-job: assert rst after the 2nd request accept → next cycle valid=0, done=1. A new start then runs cleanly from its own st_addr.

Source files
------------

// File: rtl/ddr_rd_req_gen.sv
// ddr_rd_req_gen: expands a strided 2-D DDR read job into bounded read requests.
// Each request is limited by the row remainder, MAX_LEN and the next 4 KiB boundary.
// Returned data beats are counted; done rises once every expected beat has arrived.
module ddr_rd_req_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_W    = 16,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned BEAT_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [BURST_W-1:0] burst,
  input  logic [ADDR_W-1:0] step,
  input  logic [BURST_W-1:0] burst_num,
  output logic              done,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [7:0]        rd_req_len,
  input  logic              rd_data_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  // Common width for comparing row remainder against the beat cap.
  localparam int unsigned CW         = (BURST_W > 13) ? BURST_W : 13;
  localparam int unsigned BW2        = 2 * BURST_W;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  row_base;
  logic [BURST_W-1:0] row_rem;
  logic [BURST_W-1:0] rows_left;
  logic [BURST_W-1:0] cfg_burst;
  logic [ADDR_W-1:0]  cfg_step;
  logic [BW2-1:0]     beats_exp;
  logic [BW2-1:0]     beats_rcv;
  logic               done_q;

  logic [12:0]        bytes_to_4k;
  logic [12:0]        beats_to_4k;
  logic [CW-1:0]      cap;
  logic [CW-1:0]      rem_w;
  logic [CW-1:0]      len_w;
  logic [ADDR_W-1:0]  addr_inc;
  logic [ADDR_W-1:0]  next_row;
  logic [BURST_W-1:0] row_rem_sub;
  logic               accept;
  logic               row_done;
  logic               last_req;
  logic               beat_in;
  logic [BW2-1:0]     beats_rcv_nx;
  logic               complete;

  // Request length and bookkeeping for the current request.
  always_comb begin
    bytes_to_4k  = 13'd4096 - {1'b0, cur_addr[11:0]};
    beats_to_4k  = bytes_to_4k >> BEAT_SHIFT;
    cap          = (CW'(beats_to_4k) < CW'(MAX_LEN)) ? CW'(beats_to_4k) : CW'(MAX_LEN);
    rem_w        = CW'(row_rem);
    len_w        = (rem_w < cap) ? rem_w : cap;
    addr_inc     = ADDR_W'(len_w) << BEAT_SHIFT;
    next_row     = row_base + cfg_step;
    row_rem_sub  = row_rem - BURST_W'(len_w);
    accept       = (state == REQ) && rd_req_ready;
    row_done     = (row_rem_sub == '0);
    last_req     = row_done && (rows_left == BURST_W'(1));
    beat_in      = (state != IDLE) && rd_data_valid;
    beats_rcv_nx = beats_rcv + {{(BW2-1){1'b0}}, beat_in};
    // Data may complete early, so completion is also allowed on the last accept.
    complete     = (beats_rcv_nx == beats_exp) &&
                   ((state == WAIT) || (accept && last_req));
  end

  // Output drive; length reads as zero outside REQ.
  always_comb begin
    rd_req_valid = (state == REQ);
    rd_req_addr  = cur_addr;
    rd_req_len   = (state == REQ) ? 8'(len_w - CW'(1)) : 8'd0;
    done         = done_q;
  end

  // Job state, address walk and beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      row_base  <= '0;
      row_rem   <= '0;
      rows_left <= '0;
      cfg_burst <= '0;
      cfg_step  <= '0;
      beats_exp <= '0;
      beats_rcv <= '0;
      done_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && (burst != '0) && (burst_num != '0)) begin
            cfg_burst <= burst;
            cfg_step  <= step;
            cur_addr  <= st_addr;
            row_base  <= st_addr;
            row_rem   <= burst;
            rows_left <= burst_num;
            beats_exp <= BW2'(burst) * BW2'(burst_num);
            beats_rcv <= '0;
            done_q    <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          beats_rcv <= beats_rcv_nx;
          if (accept) begin
            if (row_done) begin
              rows_left <= rows_left - BURST_W'(1);
              row_base  <= next_row;
              cur_addr  <= next_row;
              row_rem   <= cfg_burst;
            end else begin
              cur_addr  <= cur_addr + addr_inc;
              row_rem   <= row_rem_sub;
            end
            if (last_req) begin
              if (complete) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                state  <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          beats_rcv <= beats_rcv_nx;
          if (complete) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_req_gen.sv
// Scoreboard bench for ddr_rd_req_gen: directed jobs push expected requests,
// a monitor pops and compares on every accepted request.
module tb_ddr_rd_req_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] st_addr;
  logic [15:0] burst;
  logic [31:0] step;
  logic [15:0] burst_num;
  logic        done;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        rd_data_valid;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  req_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pending = 0;
  int   acc_cnt = 0;
  int   last_beat_cyc = 0;

  ddr_rd_req_gen #(
    .ADDR_W(32), .BURST_W(16), .MAX_LEN(16), .BEAT_BYTES(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .st_addr      (st_addr),
    .burst        (burst),
    .step         (step),
    .burst_num    (burst_num),
    .done         (done),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_data_valid(rd_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l);
    req_t r;
    r.addr = a;
    r.len  = l;
    exp_q.push_back(r);
  endtask

  // Monitor: compares accepted requests and checks hold stability under backpressure.
  logic        stall = 1'b0;
  logic [31:0] h_addr;
  logic [7:0]  h_len;
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall && rd_req_valid) begin
        check("hold_addr", 64'(rd_req_addr), 64'(h_addr));
        check("hold_len", 64'(rd_req_len), 64'(h_len));
      end
      if (rd_req_valid && rd_req_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexp_req: got addr 0x%0h len %0d, expected no request",
                   rd_req_addr, rd_req_len);
        end else begin
          req_t r;
          r = exp_q.pop_front();
          check("req_addr", 64'(rd_req_addr), 64'(r.addr));
          check("req_len", 64'(rd_req_len), 64'(r.len));
          pending = pending + int'(r.len) + 1;
        end
        acc_cnt++;
        stall = 1'b0;
      end else if (rd_req_valid) begin
        stall  = 1'b1;
        h_addr = rd_req_addr;
        h_len  = rd_req_len;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // Data responder: one beat per cycle for every beat owed by accepted requests.
  always @(posedge clk) begin
    #2;
    if (pending > 0) begin
      rd_data_valid = 1'b1;
      pending--;
      last_beat_cyc = cyc;
    end else begin
      rd_data_valid = 1'b0;
    end
  end

  task automatic start_job(input logic [31:0] a, input logic [15:0] b, input logic [31:0] s,
                           input logic [15:0] n);
    @(posedge clk);
    #1;
    st_addr   = a;
    burst     = b;
    step      = s;
    burst_num = n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done still 0 after 1000 cycles, expected 1", name);
    end else begin
      check({name, "_done_rise"}, 64'(cyc), 64'(last_beat_cyc + 1));
    end
    check({name, "_left_req"}, 64'(exp_q.size()), 64'd0);
    check({name, "_left_beats"}, 64'(pending), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    st_addr = '0;
    burst = '0;
    step = '0;
    burst_num = '0;
    rd_req_ready = 1'b1;
    rd_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", 64'(done), 64'd1);
    check("rst_valid", 64'(rd_req_valid), 64'd0);
    check("rst_addr", 64'(rd_req_addr), 64'd0);
    check("rst_len", 64'(rd_req_len), 64'd0);

    // Single row
    push(32'h1000, 8'd7);
    start_job(32'h1000, 16'd8, 32'h0, 16'd1);
    @(negedge clk);
    check("j1_done_low", 64'(done), 64'd0);
    check("j1_valid_lat", 64'(rd_req_valid), 64'd1);
    wait_done("j1");

    // MAX_LEN split with initial backpressure
    push(32'h000, 8'd15);
    push(32'h200, 8'd15);
    push(32'h400, 8'd7);
    rd_req_ready = 1'b0;
    start_job(32'h0, 16'd40, 32'h0, 16'd1);
    repeat (5) @(posedge clk);
    #1;
    rd_req_ready = 1'b1;
    wait_done("j2");

    // 4 KiB boundary
    push(32'h0FC0, 8'd1);
    push(32'h1000, 8'd1);
    start_job(32'h0FC0, 16'd4, 32'h0, 16'd1);
    wait_done("j3");

    // Strided rows, with an ignored start mid-job
    push(32'h2000, 8'd2);
    push(32'h2400, 8'd2);
    push(32'h2800, 8'd2);
    rd_req_ready = 1'b0;
    start_job(32'h2000, 16'd3, 32'h400, 16'd3);
    start_job(32'h9000, 16'd5, 32'h100, 16'd2);
    rd_req_ready = 1'b1;
    wait_done("j4");
    repeat (3) begin
      @(negedge clk);
      check("j4_no_extra", 64'(rd_req_valid), 64'd0);
    end

    // Illegal starts: burst_num=0, then burst=0
    start_job(32'h5000, 16'd4, 32'h0, 16'd0);
    repeat (3) begin
      @(negedge clk);
      check("bn0_done", 64'(done), 64'd1);
      check("bn0_valid", 64'(rd_req_valid), 64'd0);
    end
    start_job(32'h5000, 16'd0, 32'h0, 16'd2);
    @(negedge clk);
    check("b0_done", 64'(done), 64'd1);
    check("b0_valid", 64'(rd_req_valid), 64'd0);

    // Reset after second accept
    push(32'h000, 8'd15);
    push(32'h200, 8'd15);
    push(32'h400, 8'd7);
    begin
      int base;
      bit hit = 1'b0;
      base = acc_cnt;
      start_job(32'h0, 16'd40, 32'h0, 16'd1);
      for (int i = 0; i < 50 && !hit; i++) begin
        @(posedge clk);
        if (acc_cnt >= base + 2) hit = 1'b1;
      end
      if (!hit) begin
        tests++;
        fails++;
        $display("FAIL rst_mid_timeout: accepts %0d, expected %0d", acc_cnt - base, 2);
      end
    end
    #1;
    rst = 1'b1;
    pending = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", 64'(rd_req_valid), 64'd0);
    check("rstmid_done", 64'(done), 64'd1);

    // Clean job after reset
    push(32'h3000, 8'd7);
    start_job(32'h3000, 16'd8, 32'h0, 16'd1);
    @(negedge clk);
    check("j7_done_low", 64'(done), 64'd0);
    wait_done("j7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
